// File: rtl/eth_phy_10g_pkg.sv
// Shared 10G PHY definitions: frame geometry, sync headers and the bit-reverse
// helper used by both the RX and TX gearboxes.
package eth_phy_10g_pkg;

   localparam int FRAME_WIDTH = 66;
   localparam int HDR_WIDTH   = 2;

   // Sync headers, bit 0 is the first bit on the wire.
   localparam logic [1:0] SYNC_DATA = 2'b10;
   localparam logic [1:0] SYNC_CTRL = 2'b01;

   typedef logic [FRAME_WIDTH-1:0] frame_t;

   function automatic logic [63:0] bit_reverse64(input logic [63:0] i_word);
      logic [63:0] w_rev;
      for (int i = 0; i < 64; i++) begin
         w_rev[i] = i_word[63-i];
      end
      return w_rev;
   endfunction

endpackage

// File: rtl/eth_phy_10g_rx_gearbox.sv
// 64-bit SERDES word to 66-bit 64b/66b frame gearbox with one-bit slip
// realignment driven by the PHY block-lock logic.
module eth_phy_10g_rx_gearbox #(
   parameter int DATA_WIDTH  = 64,
   parameter int FRAME_WIDTH = eth_phy_10g_pkg::FRAME_WIDTH,
   parameter int HDR_WIDTH   = eth_phy_10g_pkg::HDR_WIDTH,
   parameter int BIT_REVERSE = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_valid,
   input  logic                   bitslip,
   output logic [FRAME_WIDTH-1:0] out_frame,
   output logic                   out_valid,
   output logic [7:0]             buf_level,
   output logic [6:0]             slip_count
);

   import eth_phy_10g_pkg::*;

   localparam int BUF_W = FRAME_WIDTH + DATA_WIDTH;

   if (DATA_WIDTH != 64 || FRAME_WIDTH != HDR_WIDTH + DATA_WIDTH) begin : g_bad_cfg
      $error("eth_phy_10g_rx_gearbox supports only 64-bit words and 66-bit frames");
   end

   logic [BUF_W-1:0]       r_buf;
   logic [7:0]             r_count;
   logic                   r_slip_d;
   logic                   r_slip_pend;
   frame_t                 r_frame;
   logic                   r_valid;
   logic [6:0]             r_slip_cnt;

   logic [DATA_WIDTH-1:0]  w_word;
   logic [BUF_W-1:0]       w_merged;
   logic [BUF_W-1:0]       w_slipped;
   logic [BUF_W-1:0]       w_next_buf;
   logic [7:0]             w_avail_in;
   logic [7:0]             w_avail_slip;
   logic [7:0]             w_next_count;
   logic                   w_slip_evt;
   logic                   w_slip_req;
   logic                   w_slip_do;
   logic                   w_next_pend;
   logic                   w_emit;
   logic [6:0]             w_next_slip_cnt;

   assign w_word = (BIT_REVERSE != 0) ? bit_reverse64(in_data) : in_data;

   // Merge, then slip, then emit: a slip in an emitting cycle shapes that frame.
   // NOTE: every always_comb output gets a default first so no path leaves a latch.
   always_comb begin
      w_merged   = r_buf;
      w_avail_in = r_count;
      if (in_valid) begin
         w_merged[r_count +: DATA_WIDTH] = w_word;
         w_avail_in                      = r_count + 8'(DATA_WIDTH);
      end

      w_slip_evt   = bitslip & ~r_slip_d;
      w_slip_req   = w_slip_evt | r_slip_pend;
      w_slip_do    = w_slip_req && (w_avail_in != 8'd0);
      w_next_pend  = w_slip_req && (w_avail_in == 8'd0);
      w_slipped    = w_slip_do ? (w_merged >> 1) : w_merged;
      w_avail_slip = w_slip_do ? (w_avail_in - 8'd1) : w_avail_in;

      w_emit       = (w_avail_slip >= 8'(FRAME_WIDTH));
      w_next_buf   = w_emit ? (w_slipped >> FRAME_WIDTH) : w_slipped;
      w_next_count = w_emit ? (w_avail_slip - 8'(FRAME_WIDTH)) : w_avail_slip;

      w_next_slip_cnt = (r_slip_cnt == 7'd65) ? 7'd0 : (r_slip_cnt + 7'd1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count     <= '0;
         r_slip_d    <= 1'b0;
         r_slip_pend <= 1'b0;
         r_frame     <= '0;
         r_valid     <= 1'b0;
         r_slip_cnt  <= '0;
      end else begin
         r_count     <= w_next_count;
         r_slip_d    <= bitslip;
         r_slip_pend <= w_next_pend;
         r_valid     <= w_emit;
         if (w_emit) begin
            r_frame <= w_slipped[FRAME_WIDTH-1:0];
         end
         if (w_slip_do) begin
            r_slip_cnt <= w_next_slip_cnt;
         end
      end
   end

   // NOTE: the bit queue is not reset; r_count alone marks which bits are live.
   always_ff @(posedge clk) begin
      r_buf <= w_next_buf;
   end

   assign out_frame  = r_frame;
   assign out_valid  = r_valid;
   assign buf_level  = r_count;
   assign slip_count = r_slip_cnt;

endmodule

// File: tb/tb_eth_phy_10g_rx_gearbox.sv
// Self-checking bench for eth_phy_10g_rx_gearbox: bit-queue reference model
// feeding a frame scoreboard, a vector table and directed corner sequences.
module tb_eth_phy_10g_rx_gearbox;

   import eth_phy_10g_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        bitslip = 1'b0;
   logic [65:0] out_frame, rev_frame;
   logic        out_valid, rev_valid;
   logic [7:0]  buf_level, rev_level;
   logic [6:0]  slip_count, rev_slip;

   always #5 clk = ~clk;

   eth_phy_10g_rx_gearbox #(.BIT_REVERSE(0)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .bitslip(bitslip),
      .out_frame(out_frame), .out_valid(out_valid), .buf_level(buf_level), .slip_count(slip_count)
   );

   eth_phy_10g_rx_gearbox #(.BIT_REVERSE(1)) u_rev (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .bitslip(bitslip),
      .out_frame(rev_frame), .out_valid(rev_valid), .buf_level(rev_level), .slip_count(rev_slip)
   );

   typedef struct {
      logic        v;
      logic [63:0] d;
      logic        s;
      logic        exp_valid;
      logic [7:0]  exp_level;
      logic [6:0]  exp_slip;
   } vec_t;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_strobes;

   bit          mq[$];
   int          m_slip;
   bit          m_pend;
   bit          m_slip_d;
   bit          m_emit;
   logic [65:0] sb[$];
   logic [65:0] got[$];
   logic [63:0] words[$];
   logic [65:0] frames[$];
   logic [63:0] ref_words[$];
   logic [65:0] ref_frames[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      sb.delete();
      m_slip   = 0;
      m_pend   = 1'b0;
      m_slip_d = 1'b0;
      m_emit   = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic [63:0] d, input logic s);
      logic [65:0] f;
      bit          evt;
      if (v) for (int i = 0; i < 64; i++) mq.push_back(d[i]);
      evt      = s && !m_slip_d;
      m_slip_d = s;
      if (evt || m_pend) begin
         if (mq.size() > 0) begin
            void'(mq.pop_front());
            m_slip = (m_slip + 1) % 66;
            m_pend = 1'b0;
         end else begin
            m_pend = 1'b1;
         end
      end
      m_emit = 1'b0;
      if (mq.size() >= 66) begin
         for (int i = 0; i < 66; i++) f[i] = mq.pop_front();
         sb.push_back(f);
         m_emit = 1'b1;
      end
   endtask

   task automatic cycle(input logic v, input logic [63:0] d, input logic s);
      logic [65:0] e;
      in_valid = v;
      in_data  = d;
      bitslip  = s;
      model_step(v, d, s);
      @(posedge clk);
      #1;
      check("out_valid", out_valid, m_emit);
      if (out_valid) begin
         n_strobes++;
         got.push_back(out_frame);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("frame", out_frame, e);
         end else begin
            n_checks++;
            n_errors++;
            $display("FAIL frame: got %h expected no frame (scoreboard empty)", out_frame);
         end
      end
      check("buf_level", buf_level, mq.size());
      check("slip_count", slip_count, m_slip);
   endtask

   task automatic do_reset(input int n);
      rst      = 1'b1;
      in_valid = 1'b0;
      bitslip  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      got.delete();
      n_strobes = 0;
   endtask

   task automatic gen_stream(input int offset, input int nframes);
      bit          bits[$];
      logic [65:0] f;
      logic [63:0] w;
      words.delete();
      frames.delete();
      for (int i = 0; i < offset; i++) bits.push_back(1'($urandom));
      for (int k = 0; k < nframes; k++) begin
         f[65:2] = {$urandom, $urandom};
         f[1:0]  = (k % 2 == 0) ? SYNC_DATA : SYNC_CTRL;
         frames.push_back(f);
         for (int i = 0; i < 66; i++) bits.push_back(f[i]);
      end
      while (bits.size() % 64 != 0) bits.push_back(1'b0);
      while (bits.size() > 0) begin
         for (int i = 0; i < 64; i++) w[i] = bits.pop_front();
         words.push_back(w);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vecs[8];
      logic [63:0] w0, w1;
      int          s0, s1, n_locked, idx;

      vecs[0] = '{1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 8'd64,  7'd0};
      vecs[1] = '{1'b0, {$urandom, $urandom}, 1'b0, 1'b0, 8'd64,  7'd0};
      vecs[2] = '{1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 8'd62,  7'd0};
      vecs[3] = '{1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 8'd60,  7'd0};
      vecs[4] = '{1'b0, {$urandom, $urandom}, 1'b1, 1'b0, 8'd59,  7'd1};
      vecs[5] = '{1'b0, {$urandom, $urandom}, 1'b1, 1'b0, 8'd59,  7'd1};
      vecs[6] = '{1'b0, {$urandom, $urandom}, 1'b0, 1'b0, 8'd59,  7'd1};
      vecs[7] = '{1'b1, {$urandom, $urandom}, 1'b1, 1'b1, 8'd56,  7'd2};

      // Reset values.
      do_reset(3);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_frame", out_frame, 66'd0);
      check("rst_buf_level", buf_level, 8'd0);
      check("rst_slip_count", slip_count, 7'd0);

      // Vector table: merge / idle / emit / slip / held slip / slip+emit.
      for (int i = 0; i < 8; i++) begin
         cycle(vecs[i].v, vecs[i].d, vecs[i].s);
         check($sformatf("tbl%0d_valid", i), out_valid, vecs[i].exp_valid);
         check($sformatf("tbl%0d_level", i), buf_level, vecs[i].exp_level);
         check($sformatf("tbl%0d_slip", i), slip_count, vecs[i].exp_slip);
      end

      // 33 continuous words carry exactly 32 aligned frames.
      do_reset(2);
      gen_stream(0, 32);
      ref_words  = words;
      ref_frames = frames;
      for (int i = 0; i < words.size(); i++) cycle(1'b1, words[i], 1'b0);
      check("t1_word_count", words.size(), 33);
      check("t1_strobes", n_strobes, 32);
      check("t1_level_end", buf_level, 8'd0);
      check("t1_got_count", got.size(), 32);
      for (int k = 0; k < 32 && k < got.size(); k++) check($sformatf("t1_frame%0d", k), got[k], ref_frames[k]);
      check("t1_sb_drained", sb.size(), 0);

      // Stream offset by 5 bits, one slip pulse every 9 cycles for 5 pulses.
      do_reset(2);
      gen_stream(5, 60);
      n_locked = 0;
      for (int c = 0; c < 50; c++) begin
         cycle(1'b1, words[c], (c % 9 == 0) && (c < 45));
         if (out_valid && m_slip == 5) begin
            n_locked++;
            check("t2_hdr_valid", (out_frame[1:0] == SYNC_DATA) || (out_frame[1:0] == SYNC_CTRL), 1'b1);
         end
      end
      check("t2_slip_count", slip_count, 7'd5);
      check("t2_locked_seen", n_locked >= 10, 1'b1);

      // bitslip held for 20 cycles slips once; then 66 slips wrap the counter.
      s0 = m_slip;
      for (int i = 0; i < 20; i++) cycle(1'b1, {$urandom, $urandom}, 1'b1);
      check("t3_one_slip", slip_count, (s0 + 1) % 66);
      cycle(1'b1, {$urandom, $urandom}, 1'b0);
      s1 = m_slip;
      for (int i = 0; i < 132; i++) cycle(1'b1, {$urandom, $urandom}, (i % 2) == 0);
      check("t3_wrap66", slip_count, s1);
      check("t3_sb_drained", sb.size(), 0);

      // Random in_valid gaps give the same frame sequence as the gap-free run.
      do_reset(2);
      idx = 0;
      for (int c = 0; c < 400 && idx < 33; c++) begin
         if ($urandom_range(0, 1) == 1) begin
            cycle(1'b1, ref_words[idx], 1'b0);
            idx++;
         end else begin
            cycle(1'b0, {$urandom, $urandom}, 1'b0);
         end
      end
      check("t4_all_words_sent", idx, 33);
      check("t4_got_count", got.size(), 32);
      for (int k = 0; k < 32 && k < got.size(); k++) check($sformatf("t4_frame%0d", k), got[k], ref_frames[k]);

      // Slip with an empty queue is deferred to the first word.
      do_reset(2);
      w0 = {$urandom, $urandom};
      w1 = {$urandom, $urandom};
      cycle(1'b0, {$urandom, $urandom}, 1'b1);
      check("t5_deferred", slip_count, 7'd0);
      cycle(1'b1, w0, 1'b0);
      check("t5_applied", slip_count, 7'd1);
      check("t5_level", buf_level, 8'd63);
      cycle(1'b1, w1, 1'b0);
      check("t5_first_valid", out_valid, 1'b1);
      check("t5_first_frame", out_frame, {w1[2:0], w0[63:1]});

      // Reset mid-stream at buf_level 40, then realign to the new first word.
      do_reset(2);
      for (int i = 0; i < 60 && (i < 3 || mq.size() != 40); i++) cycle(1'b1, {$urandom, $urandom}, (i == 0) || (i == 2));
      check("t6_level40", buf_level, 8'd40);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      bitslip  = 1'b0;
      @(posedge clk);
      #1;
      check("t6_rst_valid", out_valid, 1'b0);
      check("t6_rst_frame", out_frame, 66'd0);
      check("t6_rst_level", buf_level, 8'd0);
      check("t6_rst_slip", slip_count, 7'd0);
      rst = 1'b0;
      model_reset();
      w0 = {$urandom, $urandom};
      w1 = {$urandom, $urandom};
      cycle(1'b1, w0, 1'b0);
      cycle(1'b1, w1, 1'b0);
      check("t6_realign", out_frame, {w1[1:0], w0});

      // BIT_REVERSE: word bit 0 lands at queue position 63.
      do_reset(2);
      cycle(1'b1, 64'h1, 1'b0);
      cycle(1'b1, 64'h0, 1'b0);
      check("t7_main_frame", out_frame, 66'h1);
      check("t7_rev_valid", rev_valid, 1'b1);
      check("t7_rev_frame", rev_frame, 66'h1 << 63);
      check("t7_rev_level", rev_level, 8'd62);
      check("t7_rev_slip", rev_slip, 7'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
